// File: rtl/frame_config_loader_pkg.sv
// frame_config_loader_pkg
// Shared definitions for the FABulous column configuration loader.
//   - FSM state encoding (3-bit constants, kept as plain localparams so the
//     encoding is stable across tools and easy to match in legacy netlists)
//   - header marker value and header field positions
//   - helpers that extract the header fields from a 32-bit stream word
package frame_config_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_DRAIN  = 3'd2;
    localparam state_t ST_STROBE = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

    localparam logic [7:0] HDR_MARK     = 8'hA5;
    localparam int         HDR_MARK_LSB = 24;
    localparam int         HDR_IDX_LSB  = 0;

    // Marker byte of a header word.
    function automatic logic [7:0] hdr_mark(input logic [31:0] word);
        return word[HDR_MARK_LSB +: 8];
    endfunction

    // Frame index byte of a header word.
    function automatic logic [7:0] hdr_index(input logic [31:0] word);
        return word[HDR_IDX_LSB +: 8];
    endfunction

endpackage

// File: rtl/frame_row_register.sv
// frame_row_register
// NumRows x FrameBitsPerRow frame storage, flattened onto one bus.
//   clk        : clock (rising edge)
//   resetn     : synchronous active-low reset, clears every row
//   wr_en      : write wr_data into row wr_row this cycle
//   wr_row     : destination row
//   wr_data    : row contents
//   frame_data : row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow]
module frame_row_register
    import frame_config_loader_pkg::*;
#(
    parameter int NumRows         = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int RowCntW         = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               wr_en,
    input  logic [RowCntW-1:0]                 wr_row,
    input  logic [FrameBitsPerRow-1:0]         wr_data,
    output logic [NumRows*FrameBitsPerRow-1:0] frame_data
);

    logic [NumRows*FrameBitsPerRow-1:0] frame_d;
    logic [NumRows*FrameBitsPerRow-1:0] frame_q;

    // Row-address decode: only the addressed row changes; the rest hold.
    always_comb begin
        frame_d = frame_q;
        for (int r = 0; r < NumRows; r++) begin
            if (wr_en && (wr_row == RowCntW'(r))) begin
                frame_d[r*FrameBitsPerRow +: FrameBitsPerRow] = wr_data;
            end else begin
                frame_d[r*FrameBitsPerRow +: FrameBitsPerRow] =
                    frame_q[r*FrameBitsPerRow +: FrameBitsPerRow];
            end
        end
    end

    // Frame storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_data = frame_q;

endmodule

// File: rtl/frame_config_loader.sv
// frame_config_loader
// Assembles one column frame from a 32-bit word stream (header + NumRows
// data words) and pulses a single FrameStrobe line so every tile's
// ConfigMem in the column latches its slice.
//   UserCLK     : clock (rising edge)
//   resetn      : synchronous active-low reset
//   in_data     : stream word; in_valid/in_ready handshake
//   FrameData   : assembled column frame (row r at [r*FrameBitsPerRow +: ...])
//   FrameStrobe : one-hot, one cycle per completed frame
//   busy        : not in IDLE
//   err         : sticky; bad header marker or frame index out of range
//   frames_done : number of frames strobed, wraps at 16 bits
module frame_config_loader
    import frame_config_loader_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    input  logic [FrameBitsPerRow-1:0]         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               err,
    output logic [15:0]                        frames_done
);

    // A one-row column still needs a 1-bit counter; LastRow is then 0, so a
    // single data word completes the frame.
    localparam int                  RowCntW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [RowCntW-1:0]  LastRow = RowCntW'(NumRows - 1);

    state_t                       state_d, state_q;
    logic [RowCntW-1:0]           row_cnt_d, row_cnt_q;
    logic [7:0]                   idx_d, idx_q;
    logic                         err_d, err_q;
    logic                         busy_d, busy_q;
    logic [15:0]                  frames_done_d, frames_done_q;
    logic [MaxFramesPerCol-1:0]   strobe_d, strobe_q;
    logic [MaxFramesPerCol-1:0]   strobe_onehot_s;
    logic                         xfer_s;
    logic                         wr_en_s;

    // Words are accepted only in the three input states, never while in reset.
    assign in_ready = resetn &&
                      ((state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DRAIN));
    assign xfer_s   = in_valid && in_ready;

    // Decode the stored frame index into the strobe pattern.
    always_comb begin
        strobe_onehot_s = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            strobe_onehot_s[i] = (idx_q == 8'(i));
        end
    end

    // Sequencer next-state and output-register next values.
    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        idx_d         = idx_q;
        err_d         = err_q;
        frames_done_d = frames_done_q;
        strobe_d      = '0;
        wr_en_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (hdr_mark(in_data) != HDR_MARK) begin
                        err_d = 1'b1;
                    end else if (32'(hdr_index(in_data)) < 32'(MaxFramesPerCol)) begin
                        idx_d     = hdr_index(in_data);
                        row_cnt_d = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        // Out-of-range frame: swallow its payload so the
                        // stream stays aligned on the next header.
                        err_d     = 1'b1;
                        row_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (row_cnt_q == LastRow) begin
                        // Strobe is registered here so it is high exactly
                        // during the STROBE state.
                        row_cnt_d     = '0;
                        strobe_d      = strobe_onehot_s;
                        frames_done_d = frames_done_q + 16'd1;
                        state_d       = ST_STROBE;
                    end else begin
                        row_cnt_d = row_cnt_q + RowCntW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (xfer_s) begin
                    if (row_cnt_q == LastRow) begin
                        row_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + RowCntW'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer and output registers.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            row_cnt_q     <= '0;
            idx_q         <= 8'd0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            frames_done_q <= 16'd0;
            strobe_q      <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            frames_done_q <= frames_done_d;
            strobe_q      <= strobe_d;
        end
    end

    frame_row_register #(
        .NumRows         (NumRows),
        .FrameBitsPerRow (FrameBitsPerRow),
        .RowCntW         (RowCntW)
    ) u_rows (
        .clk        (UserCLK),
        .resetn     (resetn),
        .wr_en      (wr_en_s),
        .wr_row     (row_cnt_q),
        .wr_data    (in_data),
        .frame_data (FrameData)
    );

    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frames_done = frames_done_q;

endmodule
